good_pairs_stream: RTL

Streaming good-pairs counter (LeetCode 1512): counts index pairs (i<j) with equal values across each framed AXI-Stream-style packet of keys. It keeps an exact per-key occurrence table, adds the key's prior count to a running pair total on every accepted beat, and emits one result beat per frame on `in_tlast`. Between frames it self-clears its count table. It sits behind any keyed stream source and in front of a result consumer with backpressure.

---
 rtl/good_pairs_stream.sv | 118 +++++++++++
 1 files changed

// File: rtl/good_pairs_stream.sv
// good_pairs_stream: counts equal-key index pairs per framed stream packet, one result beat per frame.
// Optional GOOD_PAIRS_SATURATE_EN: saturating counters with a sticky overflow report.
`default_nettype none

module good_pairs_stream #(
    parameter int DATA_SIZE  = 8,
    parameter int CNT_SIZE   = 16,
    parameter int PAIRS_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_SIZE-1:0]  in_tdata,
    input  logic                  in_tvalid,
    input  logic                  in_tlast,
    output logic                  in_tready,
    output logic [PAIRS_SIZE-1:0] out_tdata,
    output logic                  out_tvalid,
    input  logic                  out_tready,
    output logic                  overflow,
    output logic                  busy
);

    localparam int DEPTH = 1 << DATA_SIZE;

    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]            state;
    logic [DATA_SIZE-1:0]  clr_addr;
    logic [PAIRS_SIZE-1:0] pairs;
    logic                  ovf_sticky;
    logic [CNT_SIZE-1:0]   cnt [DEPTH];

    logic                  accept;
    logic [CNT_SIZE-1:0]   c;
    logic [CNT_SIZE-1:0]   c_next;
    logic [PAIRS_SIZE-1:0] pairs_next;
    logic                  clip;

    assign accept = in_tvalid && (state == S_RUN);
    assign c      = cnt[in_tdata];

`ifdef GOOD_PAIRS_SATURATE_EN
    // One extra bit on each adder exposes the carry used to detect clipping.
    logic [CNT_SIZE:0]   cnt_inc;
    logic [PAIRS_SIZE:0] pairs_sum;

    always_comb begin
        cnt_inc    = {1'b0, c} + (CNT_SIZE + 1)'(1);
        pairs_sum  = {1'b0, pairs} + (PAIRS_SIZE + 1)'(c);
        c_next     = cnt_inc[CNT_SIZE] ? {CNT_SIZE{1'b1}} : cnt_inc[CNT_SIZE-1:0];
        pairs_next = pairs_sum[PAIRS_SIZE] ? {PAIRS_SIZE{1'b1}} : pairs_sum[PAIRS_SIZE-1:0];
        clip       = cnt_inc[CNT_SIZE] | pairs_sum[PAIRS_SIZE];
    end
`else
    always_comb begin
        c_next     = c + CNT_SIZE'(1);
        pairs_next = pairs + PAIRS_SIZE'(c);
        clip       = 1'b0;
    end
`endif

    // Table has no reset: its contents are only meaningful after a full CLEAR pass.
    always_ff @(posedge clk) begin
        if (state == S_CLEAR) begin
            cnt[clr_addr] <= '0;
        end else if (accept) begin
            cnt[in_tdata] <= c_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            pairs      <= '0;
            ovf_sticky <= 1'b0;
        end else begin
            case (state)
                S_CLEAR: begin
                    pairs      <= '0;
                    ovf_sticky <= 1'b0;
                    clr_addr   <= clr_addr + DATA_SIZE'(1);
                    if (clr_addr == {DATA_SIZE{1'b1}}) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        pairs      <= pairs_next;
                        ovf_sticky <= ovf_sticky | clip;
                        if (in_tlast) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_tready) begin
                        state <= S_CLEAR;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

    assign in_tready  = (state == S_RUN);
    assign out_tvalid = (state == S_DONE);
    assign busy       = (state == S_CLEAR);
    assign out_tdata  = pairs;
    assign overflow   = ovf_sticky;

endmodule

`default_nettype wire
